// File: rtl/llc.sv
// Last-level cache model: 16 MB, 16-way, 64 B lines, MESI coherence, tree pseudo-LRU.
// Latency: one trace command per edge; a fill that must displace a valid line takes two edges.
// Backpressure: hold=1 while an eviction is in flight; op/addr are ignored on the completion edge.

package LLC_defs;
   parameter int NUM_SETS      = 16384;
   parameter int ASSOCIATIVITY = 16;

   typedef enum logic [1:0] {I = 2'd0, S, E, M} mesiState;

   typedef struct packed {
      logic       valid;
      logic [11:0] tag;
      mesiState   mesi;
   } cache;

   typedef enum logic [2:0] {BUS_NONE = 3'd0, READ = 3'd1, WRITE = 3'd2,
                             INVALIDATE = 3'd3, RWIM = 3'd4} busOperation;

   typedef enum logic [1:0] {HIT = 2'b00, HITM = 2'b01, NOHIT = 2'b10} snoopResults;

   typedef enum logic [2:0] {MSG_NONE = 3'd0, GETLINE = 3'd1, SENDLINE = 3'd2,
                             INVALIDATELINE = 3'd3, EVICTLINE = 3'd4} messages;
endpackage

module llc
   import LLC_defs::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] addr,
   input  int          op,
   output int          cacheRds,
   output int          cacheWrs,
   output int          cacheHits,
   output int          cacheMisses,
   output busOperation busOp,
   output snoopResults snoopResult,
   output messages     message,
   output cache        LLC_cache [NUM_SETS][ASSOCIATIVITY],
   output int          hold
);

   // RUN: accept a new command every edge. FILL: finish the fill whose victim was just evicted.
   typedef enum logic {ST_RUN = 1'b0, ST_FILL = 1'b1} fill_st_t;

   fill_st_t    st_q, st_d;

   logic [14:0] plru [NUM_SETS];

   // command captured on the eviction edge, replayed on the completion edge
   int          pend_op;
   logic [31:0] pend_addr;

   int          cur_op;
   logic [31:0] cur_addr;
   logic [11:0] cur_tag;
   logic [13:0] cur_idx;
   logic        is_l1;

   logic        hit, has_inv, evict;
   logic [3:0]  hit_way, inv_way, vict_way;
   cache        hit_line, vict_line;

   busOperation nb_busop;
   snoopResults nb_snoop;
   messages     nb_msg;
   logic        line_we, plru_we, clr_all;
   logic [3:0]  line_way;
   cache        line_new;
   logic [14:0] plru_new;
   logic        inc_rd, inc_wr, inc_hit, inc_miss;

   // byte offset within the line only matters for the snoop-response bits
   logic        unused_offset;
   assign unused_offset = ^cur_addr[5:2];

   // Walk the tree: each node bit selects lower (0) or upper (1) half.
   function automatic logic [3:0] plru_victim(input logic [14:0] t);
      logic [3:0] n;
      logic [3:0] w;
      logic       b;
      n = '0;
      w = '0;
      for (int l = 0; l < 4; l++) begin
         b = t[n];
         w = {w[2:0], b};
         n = {n[2:0], 1'b0} + 4'd1 + {3'b000, b};
      end
      return w;
   endfunction

   // Point every node on the accessed way's path away from that way.
   function automatic logic [14:0] plru_touch(input logic [14:0] t, input logic [3:0] way);
      logic [14:0] r;
      logic [3:0]  n;
      logic [3:0]  w;
      logic        b;
      r = t;
      n = '0;
      w = way;
      for (int l = 0; l < 4; l++) begin
         b    = w[3];
         r[n] = ~b;
         n    = {n[2:0], 1'b0} + 4'd1 + {3'b000, b};
         w    = {w[2:0], 1'b0};
      end
      return r;
   endfunction

   // Response the other caches give to our bus READ, encoded in the low address bits.
   function automatic snoopResults other_resp(input logic [1:0] a);
      snoopResults r;
      case (a)
         2'b00:   r = HIT;
         2'b01:   r = HITM;
         default: r = NOHIT;
      endcase
      return r;
   endfunction

   // Select the live command: the bus inputs, or the replayed one while finishing a fill.
   always_comb begin
      cur_op   = (st_q == ST_FILL) ? pend_op : op;
      cur_addr = (st_q == ST_FILL) ? pend_addr : addr;
      cur_tag  = cur_addr[31:20];
      cur_idx  = cur_addr[19:6];
      is_l1    = (cur_op == 0) || (cur_op == 1) || (cur_op == 2);
   end

   // Tag lookup in the indexed set: hit way, lowest invalid way and PLRU victim.
   always_comb begin
      hit     = 1'b0;
      hit_way = '0;
      has_inv = 1'b0;
      inv_way = '0;
      for (int w = ASSOCIATIVITY - 1; w >= 0; w--) begin
         if (LLC_cache[cur_idx][4'(w)].valid && (LLC_cache[cur_idx][4'(w)].tag == cur_tag)) begin
            hit     = 1'b1;
            hit_way = 4'(w);
         end
         if (!LLC_cache[cur_idx][4'(w)].valid) begin
            has_inv = 1'b1;
            inv_way = 4'(w);
         end
      end
      vict_way  = plru_victim(plru[cur_idx]);
      hit_line  = LLC_cache[cur_idx][hit_way];
      vict_line = LLC_cache[cur_idx][vict_way];
      evict     = is_l1 && !hit && !has_inv;
   end

   // State register for the two-edge eviction sequence.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) st_q <= ST_RUN;
      else        st_q <= st_d;
   end

   // Next state: a full-set miss parks one edge in FILL; FILL always returns to RUN.
   always_comb begin
      st_d = ST_RUN;
      if (st_q == ST_RUN && evict) st_d = ST_FILL;
   end

   // Command decode: bus/snoop/message results, line and PLRU updates, counter increments.
   always_comb begin
      nb_busop = BUS_NONE;
      nb_snoop = NOHIT;
      nb_msg   = MSG_NONE;
      line_we  = 1'b0;
      line_way = hit_way;
      line_new = hit_line;
      plru_we  = 1'b0;
      plru_new = plru[cur_idx];
      inc_rd   = 1'b0;
      inc_wr   = 1'b0;
      inc_hit  = 1'b0;
      inc_miss = 1'b0;
      clr_all  = 1'b0;
      if (evict) begin
         // first edge of a displacing fill: push the victim out, stats wait for completion
         nb_busop       = (vict_line.mesi == M) ? WRITE : BUS_NONE;
         nb_msg         = EVICTLINE;
         line_we        = 1'b1;
         line_way       = vict_way;
         line_new       = vict_line;
         line_new.valid = 1'b0;
         line_new.mesi  = I;
      end else begin
         case (cur_op)
            0, 2: begin
               inc_rd  = 1'b1;
               nb_msg  = SENDLINE;
               plru_we = 1'b1;
               if (hit) begin
                  inc_hit  = 1'b1;
                  plru_new = plru_touch(plru[cur_idx], hit_way);
               end else begin
                  inc_miss       = 1'b1;
                  nb_busop       = READ;
                  nb_snoop       = other_resp(cur_addr[1:0]);
                  line_we        = 1'b1;
                  line_way       = inv_way;
                  line_new.valid = 1'b1;
                  line_new.tag   = cur_tag;
                  line_new.mesi  = (other_resp(cur_addr[1:0]) == NOHIT) ? E : S;
                  plru_new       = plru_touch(plru[cur_idx], inv_way);
               end
            end
            1: begin
               inc_wr  = 1'b1;
               nb_msg  = SENDLINE;
               plru_we = 1'b1;
               line_we = 1'b1;
               if (hit) begin
                  inc_hit       = 1'b1;
                  if (hit_line.mesi == S) nb_busop = INVALIDATE;
                  line_new.mesi = M;
                  plru_new      = plru_touch(plru[cur_idx], hit_way);
               end else begin
                  inc_miss       = 1'b1;
                  nb_busop       = RWIM;
                  line_way       = inv_way;
                  line_new.valid = 1'b1;
                  line_new.tag   = cur_tag;
                  line_new.mesi  = M;
                  plru_new       = plru_touch(plru[cur_idx], inv_way);
               end
            end
            3: begin
               if (hit) begin
                  line_we       = 1'b1;
                  line_new.mesi = S;
                  if (hit_line.mesi == M) begin
                     nb_snoop = HITM;
                     nb_busop = WRITE;
                     nb_msg   = GETLINE;
                  end else begin
                     nb_snoop = HIT;
                  end
               end
            end
            5: begin
               if (hit) begin
                  line_we        = 1'b1;
                  line_new.valid = 1'b0;
                  line_new.mesi  = I;
                  if (hit_line.mesi == M) begin
                     nb_snoop = HITM;
                     nb_busop = WRITE;
                     nb_msg   = EVICTLINE;
                  end else begin
                     nb_snoop = HIT;
                     nb_msg   = INVALIDATELINE;
                  end
               end
            end
            6: begin
               if (hit && hit_line.mesi == S) begin
                  nb_snoop       = HIT;
                  nb_msg         = INVALIDATELINE;
                  line_we        = 1'b1;
                  line_new.valid = 1'b0;
                  line_new.mesi  = I;
               end
            end
            8: clr_all = 1'b1;
            default: ;
         endcase
      end
   end

   // Tag array, PLRU bits, counters and registered outputs; op 8 mirrors reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         LLC_cache   <= '{default: '0};
         plru        <= '{default: '0};
         cacheRds    <= 0;
         cacheWrs    <= 0;
         cacheHits   <= 0;
         cacheMisses <= 0;
         busOp       <= BUS_NONE;
         snoopResult <= NOHIT;
         message     <= MSG_NONE;
         pend_op     <= 0;
         pend_addr   <= '0;
      end else if (clr_all) begin
         LLC_cache   <= '{default: '0};
         plru        <= '{default: '0};
         cacheRds    <= 0;
         cacheWrs    <= 0;
         cacheHits   <= 0;
         cacheMisses <= 0;
         busOp       <= BUS_NONE;
         snoopResult <= NOHIT;
         message     <= MSG_NONE;
         pend_op     <= 0;
         pend_addr   <= '0;
      end else begin
         if (line_we) LLC_cache[cur_idx][line_way] <= line_new;
         if (plru_we) plru[cur_idx] <= plru_new;
         cacheRds    <= cacheRds    + (inc_rd   ? 1 : 0);
         cacheWrs    <= cacheWrs    + (inc_wr   ? 1 : 0);
         cacheHits   <= cacheHits   + (inc_hit  ? 1 : 0);
         cacheMisses <= cacheMisses + (inc_miss ? 1 : 0);
         busOp       <= nb_busop;
         snoopResult <= nb_snoop;
         message     <= nb_msg;
         if (st_q == ST_RUN) begin
            pend_op   <= op;
            pend_addr <= addr;
         end
      end
   end

   assign hold = (st_q == ST_FILL) ? 1 : 0;

endmodule

// File: tb/tb_llc.sv
// Directed bench for llc: hand-computed MESI/PLRU/statistics expectations.
// Latency: samples outputs 1 time unit after each rising edge.
// Backpressure: holds op/addr stable across the eviction edge when hold=1.

module tb_llc;
   import LLC_defs::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] addr;
   int          op;
   int          cacheRds, cacheWrs, cacheHits, cacheMisses, hold;
   busOperation busOp;
   snoopResults snoopResult;
   messages     message;
   cache        llc_arr [NUM_SETS][ASSOCIATIVITY];

   int n_chk  = 0;
   int n_pass = 0;

   llc dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .addr        (addr),
      .op          (op),
      .cacheRds    (cacheRds),
      .cacheWrs    (cacheWrs),
      .cacheHits   (cacheHits),
      .cacheMisses (cacheMisses),
      .busOp       (busOp),
      .snoopResult (snoopResult),
      .message     (message),
      .LLC_cache   (llc_arr),
      .hold        (hold)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
   endtask

   // bus op / snoop result / message encodings:
   // busOp NONE0 READ1 WRITE2 INV3 RWIM4; snoop HIT0 HITM1 NOHIT2; msg NONE0 GET1 SEND2 INVL3 EVICT4
   task automatic chk_out(input string tag, input int bo, input int sr, input int ms);
      chk({tag, ".busOp"},   32'(busOp),       bo);
      chk({tag, ".snoop"},   32'(snoopResult), sr);
      chk({tag, ".message"}, 32'(message),     ms);
   endtask

   task automatic chk_cnt(input string tag, input int r, input int w, input int h, input int m);
      chk({tag, ".rds"},    cacheRds,    r);
      chk({tag, ".wrs"},    cacheWrs,    w);
      chk({tag, ".hits"},   cacheHits,   h);
      chk({tag, ".misses"}, cacheMisses, m);
   endtask

   // mesi I0 S1 E2 M3; t < 0 skips the tag comparison
   task automatic chk_line(input string tag, input int s, input int w, input int v, input int t, input int ms);
      chk({tag, ".valid"}, 32'(llc_arr[s][w].valid), v);
      if (t >= 0) chk({tag, ".tag"}, 32'(llc_arr[s][w].tag), t);
      chk({tag, ".mesi"}, 32'(llc_arr[s][w].mesi), ms);
   endtask

   task automatic issue(input int o, input logic [31:0] a);
      op   = o;
      addr = a;
      @(posedge clk);
      #1;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      op    = 7;
      addr  = '0;
      repeat (2) @(posedge clk);
      #1;
      chk_cnt("reset", 0, 0, 0, 0);
      chk_out("reset", 0, 2, 0);
      chk("reset.hold", hold, 0);
      chk_line("reset", 1, 0, 0, 0, 0);
      rst_n = 1'b1;

      issue(0, 32'h0000_0042);
      chk_out("rd_miss_e", 1, 2, 2);
      chk_cnt("rd_miss_e", 1, 0, 0, 1);
      chk_line("rd_miss_e", 1, 0, 1, 0, 2);
      chk("rd_miss_e.hold", hold, 0);

      issue(0, 32'h0000_0042);
      chk_out("rd_hit", 0, 2, 2);
      chk_cnt("rd_hit", 2, 0, 1, 1);
      chk_line("rd_hit", 1, 0, 1, 0, 2);

      issue(0, 32'h0010_0041);
      chk_out("rd_miss_s", 1, 1, 2);
      chk_cnt("rd_miss_s", 3, 0, 1, 2);
      chk_line("rd_miss_s", 1, 1, 1, 1, 1);

      issue(1, 32'h0010_0041);
      chk_out("wr_hit_s", 3, 2, 2);
      chk_cnt("wr_hit_s", 3, 1, 2, 2);
      chk_line("wr_hit_s", 1, 1, 1, 1, 3);

      issue(3, 32'h0010_0041);
      chk_out("snp_rd_m", 2, 1, 1);
      chk_cnt("snp_rd_m", 3, 1, 2, 2);
      chk_line("snp_rd_m", 1, 1, 1, 1, 1);

      issue(6, 32'h0010_0041);
      chk_out("snp_inv_s", 0, 0, 3);
      chk_line("snp_inv_s", 1, 1, 0, -1, 0);

      issue(1, 32'h0000_0042);
      chk_out("wr_hit_e", 0, 2, 2);
      chk_cnt("wr_hit_e", 3, 2, 3, 2);
      chk_line("wr_hit_e", 1, 0, 1, 0, 3);

      issue(5, 32'h0000_0042);
      chk_out("snp_rwim_m", 2, 1, 4);
      chk_line("snp_rwim_m", 1, 0, 0, -1, 0);

      issue(0, 32'h0020_0040);
      chk_out("rd_miss_hit", 1, 0, 2);
      chk_cnt("rd_miss_hit", 4, 2, 3, 3);
      chk_line("rd_miss_hit", 1, 0, 1, 2, 1);

      issue(4, 32'h0020_0040);
      chk_out("snp_wr", 0, 2, 0);
      chk_line("snp_wr", 1, 0, 1, 2, 1);

      issue(5, 32'h0020_0040);
      chk_out("snp_rwim_s", 0, 0, 3);
      chk_line("snp_rwim_s", 1, 0, 0, -1, 0);

      issue(6, 32'h0000_0042);
      chk_out("snp_inv_absent", 0, 2, 0);

      issue(7, 32'h0000_0000);
      chk_out("noop", 0, 2, 0);
      chk_cnt("noop", 4, 2, 3, 3);

      issue(8, 32'h0000_0000);
      chk_out("clear1", 0, 2, 0);
      chk_cnt("clear1", 0, 0, 0, 0);
      chk_line("clear1", 1, 0, 0, 0, 0);

      // fill all 16 ways of set 0 with modified lines
      for (int k = 0; k < 16; k++) begin
         issue(1, 32'(k) << 20);
         chk_out($sformatf("fill%0d", k), 4, 2, 2);
         chk($sformatf("fill%0d.hold", k), hold, 0);
         chk_line($sformatf("fill%0d", k), 0, k, 1, k, 3);
      end
      chk_cnt("fill16", 0, 16, 0, 16);

      // 17th tag: victim is way 0 (modified) -> writeback, then RWIM fill
      issue(1, 32'h0100_0000);
      chk("ev17.hold", hold, 1);
      chk_out("ev17", 2, 2, 4);
      chk_line("ev17.victim", 0, 0, 0, -1, 0);
      chk_line("ev17.way1", 0, 1, 1, 1, 3);
      step();
      chk("ev17b.hold", hold, 0);
      chk_out("ev17b", 4, 2, 2);
      chk_line("ev17b", 0, 0, 1, 16, 3);
      chk_cnt("ev17b", 0, 17, 0, 17);

      // 18th tag: tree now points to way 8
      issue(1, 32'h0110_0000);
      chk("ev18.hold", hold, 1);
      chk_out("ev18", 2, 2, 4);
      chk_line("ev18.victim", 0, 8, 0, -1, 0);
      chk_line("ev18.way0", 0, 0, 1, 16, 3);
      step();
      chk("ev18b.hold", hold, 0);
      chk_line("ev18b", 0, 8, 1, 17, 3);
      chk_cnt("ev18b", 0, 18, 0, 18);

      issue(9, 32'h0100_0000);
      chk_out("print", 0, 2, 0);
      chk_cnt("print", 0, 18, 0, 18);
      chk_line("print", 0, 0, 1, 16, 3);

      // same write held for two edges executes twice
      issue(1, 32'h0100_0000);
      chk_cnt("rep1", 0, 19, 1, 18);
      chk("rep1.hold", hold, 0);
      step();
      chk_cnt("rep2", 0, 20, 2, 18);
      chk_out("rep2", 0, 2, 2);

      issue(8, 32'h0000_0000);
      chk_cnt("clear2", 0, 0, 0, 0);
      chk_line("clear2.w0", 0, 0, 0, 0, 0);
      chk_line("clear2.w8", 0, 8, 0, 0, 0);
      chk("clear2.hold", hold, 0);

      // reset asserted in the middle of an eviction
      for (int k = 0; k < 16; k++) issue(1, 32'(k) << 20);
      issue(1, 32'h0100_0000);
      chk("rstmid.hold_before", hold, 1);
      rst_n = 1'b0;
      #1;
      chk("rstmid.hold", hold, 0);
      chk_line("rstmid", 0, 0, 0, 0, 0);
      chk_cnt("rstmid", 0, 0, 0, 0);
      #1;
      rst_n = 1'b1;
      issue(7, 32'h0000_0000);
      chk("rstmid_after.hold", hold, 0);
      chk_line("rstmid_after.w0", 0, 0, 0, 0, 0);
      chk_line("rstmid_after.w1", 0, 1, 0, 0, 0);
      chk_cnt("rstmid_after", 0, 0, 0, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
